// File: rtl/mmc_spi_target.sv
// SPI-mode MMC card target: byte-level command/response FSM that serves
// single-block reads and writes from an external byte-addressed store.
module mmc_spi_target #(
  parameter int CAP_BLOCKS = 65536,
  parameter int BUSY_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmc_cs,
  input  logic        mmc_sclk,
  input  logic        mmc_do,
  output logic        mmc_di,
  output logic [31:0] st_addr,
  output logic        st_rd,
  input  logic [7:0]  st_rdata,
  output logic        st_wr,
  output logic [7:0]  st_wdata,
  output logic        card_idle,
  output logic [3:0]  card_state
);

  typedef enum logic [3:0] {
    S_HUNT, S_CMD, S_NCR, S_R1, S_RD_GAP, S_RD_TOKEN, S_RD_DATA, S_RD_CRC,
    S_WR_TOKEN, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY
  } state_e;

  localparam logic [31:0] CAP       = 32'(CAP_BLOCKS);
  localparam logic [9:0]  BUSY_LAST = 10'(BUSY_BYTES - 1);

  logic [1:0] cs_sq, do_sq;
  logic [2:0] sclk_sq;
  logic       cs_s, do_s, rise, fall, boundary;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sq   <= 2'b11;
      do_sq   <= 2'b00;
      sclk_sq <= 3'b000;
    end else begin
      cs_sq   <= {cs_sq[0], mmc_cs};
      do_sq   <= {do_sq[0], mmc_do};
      sclk_sq <= {sclk_sq[1:0], mmc_sclk};
    end
  end

  assign cs_s = cs_sq[1];
  assign do_s = do_sq[1];
  assign rise = sclk_sq[1] & ~sclk_sq[2];
  assign fall = ~sclk_sq[1] & sclk_sq[2];

  state_e      state_q, state_d, nxt;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, rxb;
  logic        di_q, di_d;
  logic [9:0]  cnt_q, cnt_d, fetch_off;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d, st_addr_q, st_addr_d;
  logic [7:0]  r1_q, r1_d, r1_c, rd_buf_q, rd_buf_d, st_wdata_q, st_wdata_d;
  logic        idle_q, idle_d, idle_c, rd_cap_q, rd_cap_d;
  logic        st_rd_q, st_rd_d, st_wr_q, st_wr_d;

  // R1 for the command just collected; evaluated at the end of the NCR byte.
  always_comb begin
    r1_c   = 8'h04;
    idle_c = idle_q;
    if (idx_q == 6'd0) begin
      r1_c   = 8'h01;
      idle_c = 1'b1;
    end else if (idx_q == 6'd1) begin
      r1_c   = 8'h00;
      idle_c = 1'b0;
    end else if (idle_q) begin
      r1_c = 8'h05;
    end else if (idx_q == 6'd16) begin
      r1_c = (arg_q == 32'd512) ? 8'h00 : 8'h40;
    end else if (idx_q == 6'd17 || idx_q == 6'd24) begin
      r1_c = (arg_q[8:0] != 9'd0 || {9'd0, arg_q[31:9]} >= CAP) ? 8'h20 : 8'h00;
    end
  end

  function automatic logic [7:0] tx_for(state_e s, logic [7:0] r1, logic [7:0] rdb);
    case (s)
      S_R1:       return r1;
      S_RD_TOKEN: return 8'hFE;
      S_RD_DATA:  return rdb;
      S_WR_RESP:  return 8'h05;
      S_WR_BUSY:  return 8'h00;
      default:    return 8'hFF;
    endcase
  endfunction

  assign rxb       = {rx_q[6:0], do_s};
  assign boundary  = rise && (bit_q == 3'd7);
  // During data bytes the fetch runs one byte ahead of the byte on the wire.
  assign fetch_off = (state_q == S_RD_DATA) ? cnt_q + 10'd1 : cnt_q;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    di_d       = di_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    r1_d       = r1_q;
    idle_d     = idle_q;
    st_addr_d  = st_addr_q;
    st_wdata_d = st_wdata_q;
    st_rd_d    = 1'b0;
    st_wr_d    = 1'b0;
    rd_cap_d   = st_rd_q;
    rd_buf_d   = rd_cap_q ? st_rdata : rd_buf_q;
    nxt        = state_q;
    if (cs_s) begin
      state_d  = S_HUNT;
      bit_d    = 3'd0;
      cnt_d    = 10'd0;
      tx_d     = 8'hFF;
      di_d     = 1'b1;
      rd_cap_d = 1'b0;
    end else begin
      if (fall) begin
        di_d = tx_q[7];
        tx_d = {tx_q[6:0], 1'b1};
      end
      if (rise) begin
        rx_d  = rxb;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd0 && (state_q == S_RD_TOKEN ||
            (state_q == S_RD_DATA && cnt_q != 10'd511))) begin
          st_rd_d   = 1'b1;
          st_addr_d = arg_q + {22'd0, fetch_off};
        end
      end
      if (boundary) begin
        case (state_q)
          S_HUNT: if (rxb[7:6] == 2'b01) begin
            idx_d = rxb[5:0];
            cnt_d = 10'd0;
            nxt   = S_CMD;
          end
          S_CMD: if (cnt_q == 10'd4) begin
            cnt_d = 10'd0;
            nxt   = S_NCR;
          end else begin
            arg_d = {arg_q[23:0], rxb};
            cnt_d = cnt_q + 10'd1;
          end
          S_NCR: begin
            r1_d   = r1_c;
            idle_d = idle_c;
            nxt    = S_R1;
          end
          S_R1: begin
            cnt_d = 10'd0;
            if (r1_q == 8'h00 && idx_q == 6'd17)      nxt = S_RD_GAP;
            else if (r1_q == 8'h00 && idx_q == 6'd24) nxt = S_WR_TOKEN;
            else                                      nxt = S_HUNT;
          end
          S_RD_GAP:   nxt = S_RD_TOKEN;
          S_RD_TOKEN: begin
            cnt_d = 10'd0;
            nxt   = S_RD_DATA;
          end
          S_RD_DATA: if (cnt_q == 10'd511) begin
            cnt_d = 10'd0;
            nxt   = S_RD_CRC;
          end else cnt_d = cnt_q + 10'd1;
          S_RD_CRC: if (cnt_q == 10'd1) begin
            cnt_d = 10'd0;
            nxt   = S_HUNT;
          end else cnt_d = cnt_q + 10'd1;
          S_WR_TOKEN: begin
            cnt_d = 10'd0;
            if (rxb == 8'hFE)      nxt = S_WR_DATA;
            else if (rxb != 8'hFF) nxt = S_HUNT;
          end
          S_WR_DATA: begin
            st_wr_d    = 1'b1;
            st_wdata_d = rxb;
            st_addr_d  = arg_q + {22'd0, cnt_q};
            if (cnt_q == 10'd511) begin
              cnt_d = 10'd0;
              nxt   = S_WR_CRC;
            end else cnt_d = cnt_q + 10'd1;
          end
          S_WR_CRC: if (cnt_q == 10'd1) begin
            cnt_d = 10'd0;
            nxt   = S_WR_RESP;
          end else cnt_d = cnt_q + 10'd1;
          S_WR_RESP: begin
            cnt_d = 10'd0;
            nxt   = S_WR_BUSY;
          end
          S_WR_BUSY: if (cnt_q == BUSY_LAST) begin
            cnt_d = 10'd0;
            nxt   = S_HUNT;
          end else cnt_d = cnt_q + 10'd1;
          default: nxt = S_HUNT;
        endcase
        state_d = nxt;
        tx_d    = tx_for(nxt, r1_d, rd_buf_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_HUNT;
      bit_q      <= 3'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'hFF;
      di_q       <= 1'b1;
      cnt_q      <= 10'd0;
      idx_q      <= 6'd0;
      arg_q      <= 32'd0;
      r1_q       <= 8'h00;
      idle_q     <= 1'b1;
      st_addr_q  <= 32'd0;
      st_wdata_q <= 8'h00;
      st_rd_q    <= 1'b0;
      st_wr_q    <= 1'b0;
      rd_cap_q   <= 1'b0;
      rd_buf_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      di_q       <= di_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      r1_q       <= r1_d;
      idle_q     <= idle_d;
      st_addr_q  <= st_addr_d;
      st_wdata_q <= st_wdata_d;
      st_rd_q    <= st_rd_d;
      st_wr_q    <= st_wr_d;
      rd_cap_q   <= rd_cap_d;
      rd_buf_q   <= rd_buf_d;
    end
  end

  assign mmc_di     = di_q;
  assign st_addr    = st_addr_q;
  assign st_rd      = st_rd_q;
  assign st_wr      = st_wr_q;
  assign st_wdata   = st_wdata_q;
  assign card_idle  = idle_q;
  assign card_state = state_q;

endmodule
